// File: rtl/writeback_pkg.sv
// Shared encodings, state type and size helpers for the writeback stage.
package writeback_pkg;

  localparam int unsigned RESULT_W = 64;

  localparam logic [2:0] OPSIZE_8  = 3'd1;
  localparam logic [2:0] OPSIZE_16 = 3'd2;
  localparam logic [2:0] OPSIZE_32 = 3'd3;
  localparam logic [2:0] OPSIZE_64 = 3'd4;

  localparam logic [1:0] STACK_PUSH = 2'b01;
  localparam logic [1:0] STACK_POP  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } wb_state_t;

  // Operand size in bytes; zero marks an illegal encoding.
  function automatic logic [3:0] op_bytes(input logic [2:0] opsize);
    case (opsize)
      OPSIZE_8:  op_bytes = 4'd1;
      OPSIZE_16: op_bytes = 4'd2;
      OPSIZE_32: op_bytes = 4'd4;
      OPSIZE_64: op_bytes = 4'd8;
      default:   op_bytes = 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] esp_update(input logic [31:0] esp,
                                             input logic [1:0]  op,
                                             input logic [3:0]  bytes);
    case (op)
      STACK_PUSH: esp_update = esp - 32'(bytes);
      STACK_POP:  esp_update = esp + 32'(bytes);
      default:    esp_update = esp;
    endcase
  endfunction

endpackage

// File: rtl/wb_mem_aligner.sv
// Splits a store of up to 8 bytes at any byte offset into aligned 32-bit beats.
module wb_mem_aligner
  import writeback_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic [RESULT_W-1:0] i_result,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2:0]          i_opsize,
  input  logic [1:0]          i_beat,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_data,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic                o_last_beat
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [1:0]  w_off;
  logic [3:0]  w_bytes;
  logic [95:0] w_window;
  logic [11:0] w_mask;
  logic [3:0]  w_span;
  logic [3:0]  w_nbeats;

  assign w_off    = i_addr[1:0];
  assign w_bytes  = op_bytes(i_opsize);
  assign w_window = {32'd0, i_result} << {w_off, 3'b000};
  assign w_mask   = ((12'd1 << w_bytes) - 12'd1) << w_off;
  // Bytes spanned from the aligned base, rounded up to whole beats.
  assign w_span   = {2'b00, w_off} + w_bytes;
  assign w_nbeats = (w_span + 4'd3) >> 2;

  assign o_mem_addr  = {i_addr[ADDR_W-1:2], 2'b00} + ADDR_W'({i_beat, 2'b00});
  assign o_mem_data  = DATA_W'(w_window >> {i_beat, 5'b00000});
  assign o_mem_be    = BE_W'(w_mask >> {i_beat, 2'b00});
  assign o_last_beat = ({2'b00, i_beat} == (w_nbeats - 4'd1));

endmodule

// File: rtl/writeback_top.sv
// Writeback stage: commits results to register files, ESP, and memory as aligned beats.
module writeback_top
  import writeback_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [RESULT_W-1:0] wb_result,
  input  logic [2:0]          wb_dest_reg,
  input  logic [ADDR_W-1:0]   wb_dest_address,
  input  logic [2:0]          wb_opsize,
  input  logic                wb_op_a_is_reg,
  input  logic                wb_op_a_is_segment,
  input  logic                wb_op_a_is_mmx,
  input  logic                wb_op_a_is_address,
  input  logic                wb_stack,
  input  logic [1:0]          wb_stack_op,
  input  logic [31:0]         wb_pc,
  input  logic [31:0]         esp_in,
  output logic                gpr_we,
  output logic [2:0]          gpr_sel,
  output logic [2:0]          gpr_opsize,
  output logic [31:0]         gpr_data,
  output logic                seg_we,
  output logic [2:0]          seg_sel,
  output logic [15:0]         seg_data,
  output logic                mmx_we,
  output logic [2:0]          mmx_sel,
  output logic [63:0]         mmx_data,
  output logic                esp_we,
  output logic [31:0]         esp_data,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                retire_valid,
  output logic [31:0]         retire_pc
);

  wb_state_t             r_state;
  logic [1:0]            r_beat;
  logic                  r_last_beat;
  logic [RESULT_W-1:0]   r_result;
  logic [ADDR_W-1:0]     r_addr;
  logic [2:0]            r_opsize;
  logic [1:0]            r_stack_op;
  logic                  r_stack_vld;
  logic [31:0]           r_esp;
  logic [31:0]           r_pc;

  wb_state_t             w_state_nxt;
  logic [1:0]            w_beat_nxt;
  logic                  w_hs;
  logic                  w_legal;
  logic                  w_stack_vld;
  logic                  w_capture;
  logic                  w_mem_load;
  logic                  w_gpr_we_nxt;
  logic                  w_seg_we_nxt;
  logic                  w_mmx_we_nxt;
  logic                  w_esp_we_nxt;
  logic                  w_retire_nxt;
  logic                  w_mem_valid_nxt;
  logic [31:0]           w_esp_data_nxt;
  logic [31:0]           w_retire_pc_nxt;

  logic [RESULT_W-1:0]   w_al_result;
  logic [ADDR_W-1:0]     w_al_addr_in;
  logic [2:0]            w_al_opsize;
  logic [1:0]            w_al_beat;
  logic [ADDR_W-1:0]     w_al_addr;
  logic [DATA_W-1:0]     w_al_data;
  logic [DATA_W/8-1:0]   w_al_be;
  logic                  w_al_last;

  assign w_hs        = wb_valid & wb_ready & ~flush;
  assign w_legal     = (op_bytes(wb_opsize) != 4'd0);
  assign w_stack_vld = wb_stack & ((wb_stack_op == STACK_PUSH) | (wb_stack_op == STACK_POP));

  // In IDLE the aligner prepares beat 0 of the incoming store; in MEM the next beat.
  assign w_al_result  = (r_state == ST_IDLE) ? wb_result       : r_result;
  assign w_al_addr_in = (r_state == ST_IDLE) ? wb_dest_address : r_addr;
  assign w_al_opsize  = (r_state == ST_IDLE) ? wb_opsize       : r_opsize;
  assign w_al_beat    = (r_state == ST_IDLE) ? 2'd0            : r_beat + 2'd1;

  wb_mem_aligner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_aligner (
    .i_result    (w_al_result),
    .i_addr      (w_al_addr_in),
    .i_opsize    (w_al_opsize),
    .i_beat      (w_al_beat),
    .o_mem_addr  (w_al_addr),
    .o_mem_data  (w_al_data),
    .o_mem_be    (w_al_be),
    .o_last_beat (w_al_last)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_capture       = 1'b0;
    w_mem_load      = 1'b0;
    w_gpr_we_nxt    = 1'b0;
    w_seg_we_nxt    = 1'b0;
    w_mmx_we_nxt    = 1'b0;
    w_esp_we_nxt    = 1'b0;
    w_retire_nxt    = 1'b0;
    w_mem_valid_nxt = 1'b0;
    w_esp_data_nxt  = esp_data;
    w_retire_pc_nxt = retire_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_capture = 1'b1;
          if (w_legal && wb_op_a_is_address &&
              !(wb_op_a_is_reg || wb_op_a_is_segment || wb_op_a_is_mmx)) begin
            w_state_nxt     = ST_MEM;
            w_beat_nxt      = 2'd0;
            w_mem_valid_nxt = 1'b1;
            w_mem_load      = 1'b1;
          end else begin
            w_retire_nxt    = 1'b1;
            w_retire_pc_nxt = wb_pc;
            if (w_legal) begin
              w_gpr_we_nxt = wb_op_a_is_reg;
              w_seg_we_nxt = wb_op_a_is_segment & ~wb_op_a_is_reg;
              w_mmx_we_nxt = wb_op_a_is_mmx & ~wb_op_a_is_reg & ~wb_op_a_is_segment;
              if (w_stack_vld && (wb_op_a_is_reg || wb_op_a_is_segment || wb_op_a_is_mmx)) begin
                w_esp_we_nxt   = 1'b1;
                w_esp_data_nxt = esp_update(esp_in, wb_stack_op, op_bytes(wb_opsize));
              end
            end
          end
        end
      end
      ST_MEM: begin
        // Flush is deliberately ignored here so a store is never torn.
        w_mem_valid_nxt = 1'b1;
        if (mem_ready) begin
          if (r_last_beat) begin
            w_state_nxt     = ST_IDLE;
            w_mem_valid_nxt = 1'b0;
            w_retire_nxt    = 1'b1;
            w_retire_pc_nxt = r_pc;
            if (r_stack_vld) begin
              w_esp_we_nxt   = 1'b1;
              w_esp_data_nxt = esp_update(r_esp, r_stack_op, op_bytes(r_opsize));
            end
          end else begin
            w_beat_nxt = r_beat + 2'd1;
            w_mem_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_beat       <= 2'd0;
      r_last_beat  <= 1'b0;
      r_result     <= '0;
      r_addr       <= '0;
      r_opsize     <= 3'd0;
      r_stack_op   <= 2'd0;
      r_stack_vld  <= 1'b0;
      r_esp        <= 32'd0;
      r_pc         <= 32'd0;
      wb_ready     <= 1'b1;
      gpr_we       <= 1'b0;
      gpr_sel      <= 3'd0;
      gpr_opsize   <= 3'd0;
      gpr_data     <= 32'd0;
      seg_we       <= 1'b0;
      seg_sel      <= 3'd0;
      seg_data     <= 16'd0;
      mmx_we       <= 1'b0;
      mmx_sel      <= 3'd0;
      mmx_data     <= 64'd0;
      esp_we       <= 1'b0;
      esp_data     <= 32'd0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_be       <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      wb_ready     <= (w_state_nxt == ST_IDLE);
      gpr_we       <= w_gpr_we_nxt;
      seg_we       <= w_seg_we_nxt;
      mmx_we       <= w_mmx_we_nxt;
      esp_we       <= w_esp_we_nxt;
      esp_data     <= w_esp_data_nxt;
      mem_valid    <= w_mem_valid_nxt;
      retire_valid <= w_retire_nxt;
      retire_pc    <= w_retire_pc_nxt;
      if (w_capture) begin
        r_result    <= wb_result;
        r_addr      <= wb_dest_address;
        r_opsize    <= wb_opsize;
        r_stack_op  <= wb_stack_op;
        r_stack_vld <= w_stack_vld;
        r_esp       <= esp_in;
        r_pc        <= wb_pc;
      end
      if (w_gpr_we_nxt) begin
        gpr_sel    <= wb_dest_reg;
        gpr_opsize <= wb_opsize;
        gpr_data   <= wb_result[31:0];
      end
      if (w_seg_we_nxt) begin
        seg_sel  <= wb_dest_reg;
        seg_data <= wb_result[15:0];
      end
      if (w_mmx_we_nxt) begin
        mmx_sel  <= wb_dest_reg;
        mmx_data <= wb_result;
      end
      if (w_mem_load) begin
        mem_addr    <= w_al_addr;
        mem_data    <= w_al_data;
        mem_be      <= w_al_be;
        r_last_beat <= w_al_last;
      end
    end
  end

endmodule

// File: tb/tb_writeback_top.sv
// Directed bench for writeback_top: register-path vector table plus store sequences.
module tb_writeback_top;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, wb_valid, wb_ready;
  logic [63:0] wb_result;
  logic [2:0]  wb_dest_reg, wb_opsize;
  logic [31:0] wb_dest_address, wb_pc, esp_in;
  logic        wb_op_a_is_reg, wb_op_a_is_segment, wb_op_a_is_mmx, wb_op_a_is_address;
  logic        wb_stack;
  logic [1:0]  wb_stack_op;
  logic        gpr_we, seg_we, mmx_we, esp_we, mem_valid, mem_ready, retire_valid;
  logic [2:0]  gpr_sel, gpr_opsize, seg_sel, mmx_sel;
  logic [31:0] gpr_data, esp_data, mem_addr, mem_data, retire_pc;
  logic [15:0] seg_data;
  logic [63:0] mmx_data;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  writeback_top #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_dest_reg(wb_dest_reg), .wb_dest_address(wb_dest_address), .wb_opsize(wb_opsize),
    .wb_op_a_is_reg(wb_op_a_is_reg), .wb_op_a_is_segment(wb_op_a_is_segment),
    .wb_op_a_is_mmx(wb_op_a_is_mmx), .wb_op_a_is_address(wb_op_a_is_address),
    .wb_stack(wb_stack), .wb_stack_op(wb_stack_op), .wb_pc(wb_pc), .esp_in(esp_in),
    .gpr_we(gpr_we), .gpr_sel(gpr_sel), .gpr_opsize(gpr_opsize), .gpr_data(gpr_data),
    .seg_we(seg_we), .seg_sel(seg_sel), .seg_data(seg_data),
    .mmx_we(mmx_we), .mmx_sel(mmx_sel), .mmx_data(mmx_data),
    .esp_we(esp_we), .esp_data(esp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_be(mem_be),
    .retire_valid(retire_valid), .retire_pc(retire_pc)
  );

  typedef struct {
    logic [2:0]  opsize;
    logic [3:0]  kind;      // {reg, seg, mmx, addr}
    logic [2:0]  dreg;
    logic [63:0] result;
    logic        stack;
    logic [1:0]  sop;
    logic [31:0] esp;
    logic [31:0] pc;
    logic        e_gpr;
    logic        e_seg;
    logic        e_mmx;
    logic        e_esp_we;
    logic [31:0] e_esp;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; flush = 1'b0; wb_result = 64'd0; wb_dest_reg = 3'd0;
    wb_dest_address = 32'd0; wb_opsize = 3'd0; wb_op_a_is_reg = 1'b0;
    wb_op_a_is_segment = 1'b0; wb_op_a_is_mmx = 1'b0; wb_op_a_is_address = 1'b0;
    wb_stack = 1'b0; wb_stack_op = 2'b00; wb_pc = 32'd0; esp_in = 32'd0;
  endtask

  // Presents one store for a single cycle; returns at the negedge where beat 0 is visible.
  task automatic begin_store(input logic [31:0] addr, input logic [63:0] res,
                             input logic [2:0] opsz, input logic stk, input logic [1:0] sop,
                             input logic [31:0] esp, input logic [31:0] pc);
    wb_valid = 1'b1; wb_op_a_is_address = 1'b1; wb_dest_address = addr;
    wb_result = res; wb_opsize = opsz; wb_stack = stk; wb_stack_op = sop;
    esp_in = esp; wb_pc = pc;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic beat(input string nm, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [3:0] ebe, input int stall, input bit last,
                      input bit e_esp_we, input logic [31:0] e_esp, input logic [31:0] epc);
    check({nm, " mem_valid"}, mem_valid, 1);
    check({nm, " mem_addr"}, mem_addr, ea);
    check({nm, " mem_data"}, mem_data, ed);
    check({nm, " mem_be"}, mem_be, ebe);
    check({nm, " wb_ready busy"}, wb_ready, 0);
    check({nm, " no early retire"}, retire_valid, 0);
    check({nm, " no early esp_we"}, esp_we, 0);
    for (int s = 0; s < stall; s++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      check({nm, " held valid"}, mem_valid, 1);
      check({nm, " held addr"}, mem_addr, ea);
      check({nm, " held data"}, mem_data, ed);
      check({nm, " held be"}, mem_be, ebe);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    if (last) begin
      check({nm, " done mem_valid"}, mem_valid, 0);
      check({nm, " retire"}, retire_valid, 1);
      check({nm, " retire_pc"}, retire_pc, epc);
      check({nm, " esp_we"}, esp_we, e_esp_we);
      if (e_esp_we) check({nm, " esp_data"}, esp_data, e_esp);
      check({nm, " wb_ready back"}, wb_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd3, 4'b1000, 3'd3, 64'h0000_0000_1234_5678, 1'b0, 2'b00, 32'h0,    32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'h1234_5678};
    vecs[1]  = '{3'd1, 4'b1000, 3'd5, 64'h1111_2222_3333_44EF, 1'b0, 2'b00, 32'h0,    32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'h3333_44EF};
    vecs[2]  = '{3'd2, 4'b0100, 3'd2, 64'hFFFF_FFFF_FFFF_1234, 1'b0, 2'b00, 32'h0,    32'h108, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    64'h1234};
    vecs[3]  = '{3'd4, 4'b0010, 3'd7, 64'h0123_4567_89AB_CDEF, 1'b0, 2'b00, 32'h0,    32'h10C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    64'h0123_4567_89AB_CDEF};
    vecs[4]  = '{3'd3, 4'b1000, 3'd0, 64'h55,                  1'b1, 2'b01, 32'h2000, 32'h110, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1FFC, 64'h55};
    vecs[5]  = '{3'd2, 4'b1000, 3'd1, 64'hBEEF,                1'b1, 2'b10, 32'h3000, 32'h114, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3002, 64'hBEEF};
    vecs[6]  = '{3'd5, 4'b1000, 3'd4, 64'h77,                  1'b0, 2'b00, 32'h0,    32'h118, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    64'h0};
    vecs[7]  = '{3'd3, 4'b0000, 3'd0, 64'h99,                  1'b1, 2'b01, 32'h4000, 32'h11C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    64'h0};
    vecs[8]  = '{3'd4, 4'b0010, 3'd1, 64'hA5A5,                1'b1, 2'b10, 32'h100,  32'h120, 1'b0, 1'b0, 1'b1, 1'b1, 32'h108,  64'hA5A5};
    vecs[9]  = '{3'd1, 4'b1000, 3'd6, 64'h42,                  1'b1, 2'b11, 32'h500,  32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'h42};
    vecs[10] = '{3'd0, 4'b0100, 3'd0, 64'h1,                   1'b0, 2'b00, 32'h0,    32'h128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    64'h0};
    vecs[11] = '{3'd2, 4'b0100, 3'd6, 64'h0000_0000_0001_8000, 1'b1, 2'b01, 32'h10,   32'h12C, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0E,   64'h8000};

    idle_inputs();
    mem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset wb_ready", wb_ready, 1);
    check("reset gpr_we", gpr_we, 0);
    check("reset mem_valid", mem_valid, 0);
    check("reset retire_valid", retire_valid, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset gpr_data", gpr_data, 0);
    check("reset esp_data", esp_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Register-path table, applied back-to-back with no idle cycles.
    for (int i = 0; i < 12; i++) begin
      wb_valid = 1'b1; wb_opsize = vecs[i].opsize; wb_dest_reg = vecs[i].dreg;
      {wb_op_a_is_reg, wb_op_a_is_segment, wb_op_a_is_mmx, wb_op_a_is_address} = vecs[i].kind;
      wb_result = vecs[i].result; wb_stack = vecs[i].stack; wb_stack_op = vecs[i].sop;
      esp_in = vecs[i].esp; wb_pc = vecs[i].pc;
      @(negedge clk);
      check($sformatf("v%0d gpr_we", i), gpr_we, vecs[i].e_gpr);
      check($sformatf("v%0d seg_we", i), seg_we, vecs[i].e_seg);
      check($sformatf("v%0d mmx_we", i), mmx_we, vecs[i].e_mmx);
      check($sformatf("v%0d esp_we", i), esp_we, vecs[i].e_esp_we);
      check($sformatf("v%0d retire", i), retire_valid, 1);
      check($sformatf("v%0d retire_pc", i), retire_pc, vecs[i].pc);
      check($sformatf("v%0d wb_ready", i), wb_ready, 1);
      if (vecs[i].e_gpr) begin
        check($sformatf("v%0d gpr_data", i), gpr_data, vecs[i].e_data);
        check($sformatf("v%0d gpr_sel", i), gpr_sel, vecs[i].dreg);
        check($sformatf("v%0d gpr_opsize", i), gpr_opsize, vecs[i].opsize);
      end
      if (vecs[i].e_seg) begin
        check($sformatf("v%0d seg_data", i), seg_data, vecs[i].e_data);
        check($sformatf("v%0d seg_sel", i), seg_sel, vecs[i].dreg);
      end
      if (vecs[i].e_mmx) begin
        check($sformatf("v%0d mmx_data", i), mmx_data, vecs[i].e_data);
        check($sformatf("v%0d mmx_sel", i), mmx_sel, vecs[i].dreg);
      end
      if (vecs[i].e_esp_we) check($sformatf("v%0d esp_data", i), esp_data, vecs[i].e_esp);
    end
    idle_inputs();
    @(negedge clk);
    check("idle no gpr_we", gpr_we, 0);
    check("idle no retire", retire_valid, 0);

    // Flush in IDLE drops the transfer.
    wb_valid = 1'b1; flush = 1'b1; wb_op_a_is_reg = 1'b1; wb_opsize = 3'd3;
    wb_result = 64'hABCD; wb_pc = 32'h200;
    @(negedge clk);
    idle_inputs();
    check("flush no gpr_we", gpr_we, 0);
    check("flush no retire", retire_valid, 0);
    @(negedge clk);
    check("flush still no retire", retire_valid, 0);

    // Aligned dword store, ready held off for two cycles.
    begin_store(32'h1000, 64'hDEAD_BEEF, 3'd3, 1'b0, 2'b00, 32'h0, 32'h300);
    beat("dw", 32'h1000, 32'hDEAD_BEEF, 4'b1111, 2, 1'b1, 1'b0, 32'h0, 32'h300);
    @(negedge clk);
    check("dw retire once", retire_valid, 0);

    // Byte store at offset 2.
    begin_store(32'h1002, 64'hAB, 3'd1, 1'b0, 2'b00, 32'h0, 32'h304);
    beat("b2", 32'h1000, 32'h00AB_0000, 4'b0100, 0, 1'b1, 1'b0, 32'h0, 32'h304);

    // Unaligned qword spanning three beats.
    begin_store(32'h1003, 64'h1122_3344_5566_7788, 3'd4, 1'b0, 2'b00, 32'h0, 32'h308);
    beat("qw0", 32'h1000, 32'h8800_0000, 4'b1000, 0, 1'b0, 1'b0, 32'h0, 32'h308);
    beat("qw1", 32'h1004, 32'h4455_6677, 4'b1111, 0, 1'b0, 1'b0, 32'h0, 32'h308);
    beat("qw2", 32'h1008, 32'h0011_2233, 4'b0111, 0, 1'b1, 1'b0, 32'h0, 32'h308);

    // Push to memory: ESP moves with the last beat only.
    begin_store(32'h1FFC, 64'hCAFE_F00D, 3'd3, 1'b1, 2'b01, 32'h2000, 32'h30C);
    beat("push", 32'h1FFC, 32'hCAFE_F00D, 4'b1111, 1, 1'b1, 1'b1, 32'h1FFC, 32'h30C);
    @(negedge clk);
    check("push retire once", retire_valid, 0);
    check("push esp_we once", esp_we, 0);

    // Flush and a competing request during MEM, long stall on the second beat.
    begin_store(32'h1003, 64'h1122_3344_5566_7788, 3'd4, 1'b0, 2'b00, 32'h0, 32'h310);
    flush = 1'b1; wb_valid = 1'b1; wb_op_a_is_reg = 1'b1; wb_opsize = 3'd3; wb_pc = 32'h999;
    beat("fl0", 32'h1000, 32'h8800_0000, 4'b1000, 0, 1'b0, 1'b0, 32'h0, 32'h310);
    beat("fl1", 32'h1004, 32'h4455_6677, 4'b1111, 5, 1'b0, 1'b0, 32'h0, 32'h310);
    beat("fl2", 32'h1008, 32'h0011_2233, 4'b0111, 0, 1'b1, 1'b0, 32'h0, 32'h310);
    idle_inputs();
    check("fl no gpr_we", gpr_we, 0);

    // Reset mid-MEM aborts the store.
    begin_store(32'h1002, 64'h5566_7788, 3'd3, 1'b0, 2'b00, 32'h0, 32'h314);
    check("rst beat0 valid", mem_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst mem_valid", mem_valid, 0);
    check("rst wb_ready", wb_ready, 1);
    check("rst retire", retire_valid, 0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst still idle", mem_valid, 0);
    check("rst no retire", retire_valid, 0);

    // Register write works straight after the abort.
    wb_valid = 1'b1; wb_op_a_is_reg = 1'b1; wb_opsize = 3'd3; wb_dest_reg = 3'd2;
    wb_result = 64'h0BAD_F00D; wb_pc = 32'h318;
    @(negedge clk);
    idle_inputs();
    check("post-rst gpr_we", gpr_we, 1);
    check("post-rst gpr_data", gpr_data, 32'h0BAD_F00D);
    check("post-rst retire_pc", retire_pc, 32'h318);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
